// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// awprot/arprot are intentionally absent; the master never drives them.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one register command in, one response out,
// with the transaction latency measured in a saturating 16-bit counter.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32  // 32 or 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_we,
  output logic [15:0]             rsp_cycles,
  axi_lite_cmd_master_if.master   m_axi_lite
);

  typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRdAddr, StRdData, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    we_q;
  logic                    awvalid_q, wvalid_q, arvalid_q;
  logic [15:0]             cnt_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;

  logic accept, busy, aw_done, w_done;

  assign accept  = cmd_valid && cmd_ready;
  assign busy    = state_q inside {StWr, StWrResp, StRdAddr, StRdData};
  // A channel counts as done once its valid has dropped or its handshake fires now.
  assign aw_done = !awvalid_q || m_axi_lite.awready;
  assign w_done  = !wvalid_q || m_axi_lite.wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = cmd_we ? StWr : StRdAddr;
      StWr:     if (aw_done && w_done) state_d = StWrResp;
      StWrResp: if (m_axi_lite.bvalid) state_d = StResp;
      StRdAddr: if (m_axi_lite.arready) state_d = StRdData;
      StRdData: if (m_axi_lite.rvalid) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    // Gating with areset keeps cmd_ready low while reset is held.
    cmd_ready          = (state_q == StIdle) && !areset;
    rsp_valid          = (state_q == StResp);
    m_axi_lite.bready  = (state_q == StWrResp);
    m_axi_lite.rready  = (state_q == StRdData);
    m_axi_lite.awvalid = awvalid_q;
    m_axi_lite.wvalid  = wvalid_q;
    m_axi_lite.arvalid = arvalid_q;
    m_axi_lite.awaddr  = addr_q;
    m_axi_lite.araddr  = addr_q;
    m_axi_lite.wdata   = wdata_q;
    m_axi_lite.wstrb   = wstrb_q;
    rsp_rdata          = rdata_q;
    rsp_resp           = resp_q;
    rsp_we             = we_q;
    rsp_cycles         = cnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else if (accept) begin
      addr_q    <= cmd_addr;
      wdata_q   <= cmd_wdata;
      wstrb_q   <= cmd_wstrb;
      we_q      <= cmd_we;
      awvalid_q <= cmd_we;
      wvalid_q  <= cmd_we;
      arvalid_q <= !cmd_we;
      cnt_q     <= '0;
    end else begin
      if (awvalid_q && m_axi_lite.awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi_lite.wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && m_axi_lite.arready) arvalid_q <= 1'b0;
      if (busy && (cnt_q != 16'hFFFF))     cnt_q     <= cnt_q + 16'd1;
      if ((state_q == StWrResp) && m_axi_lite.bvalid) begin
        resp_q  <= m_axi_lite.bresp;
        rdata_q <= '0;
      end
      if ((state_q == StRdData) && m_axi_lite.rvalid) begin
        resp_q  <= m_axi_lite.rresp;
        rdata_q <= m_axi_lite.rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master against a small AXI4-Lite register-bank slave
// whose per-channel ready/valid delays are set by each test.
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_we;
  logic [15:0] rsp_cycles;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_we     (rsp_we),
    .rsp_cycles (rsp_cycles),
    .m_axi_lite (axi)
  );

  always #5 aclk = ~aclk;

  // Slave configuration (written by the main flow only).
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;

  // Slave state and monitors (written by the slave process only).
  logic [31:0] mem [16];
  bit          aw_got, w_got, ar_got, b_pend, r_pend, prev_arvalid;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] wr_addr, wr_data, rd_addr, prev_araddr;
  logic [3:0]  wr_strb;
  int          aw_hs_cnt = 0, bready_cyc = 0, w_drop_cnt = 0, ar_unstable = 0;

  int total = 0;
  int bad = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
    axi.bresp = '0;
    axi.rresp = '0;
    axi.rdata = '0;
    {aw_got, w_got, ar_got, b_pend, r_pend, prev_arvalid} = '0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
    prev_araddr = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid} = '0;
        {aw_got, w_got, ar_got, b_pend, r_pend, prev_arvalid} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
      end else begin
        if (axi.bready) bready_cyc++;
        if (axi.awvalid && !axi.wvalid) w_drop_cnt++;
        if (axi.arvalid && prev_arvalid && (axi.araddr != prev_araddr)) ar_unstable++;
        prev_arvalid = axi.arvalid;
        prev_araddr  = axi.araddr;
        // B channel: retire a handshake that fired on the edge just past.
        if (b_pend) begin
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] = wr_data[8*b +: 8];
          axi.bvalid = 1'b0;
          {b_pend, aw_got, w_got} = '0;
          b_cnt = 0;
        end else if (aw_got && w_got && !axi.bvalid) begin
          if (b_cnt >= b_delay) begin
            axi.bvalid = 1'b1;
            axi.bresp  = bresp_cfg;
          end else b_cnt++;
        end
        if (axi.bvalid && axi.bready) b_pend = 1'b1;
        // R channel
        if (r_pend) begin
          axi.rvalid = 1'b0;
          {r_pend, ar_got} = '0;
          r_cnt = 0;
        end else if (ar_got && !axi.rvalid) begin
          if (r_cnt >= r_delay) begin
            axi.rvalid = 1'b1;
            axi.rdata  = mem[rd_addr[5:2]];
            axi.rresp  = 2'b00;
          end else r_cnt++;
        end
        if (axi.rvalid && axi.rready) r_pend = 1'b1;
        // AW / W / AR ready generation
        if (axi.awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) begin
            axi.awready = 1'b1;
            aw_got = 1'b1;
            aw_cnt = 0;
            wr_addr = axi.awaddr;
            aw_hs_cnt++;
          end else begin
            axi.awready = 1'b0;
            aw_cnt++;
          end
        end else axi.awready = 1'b0;
        if (axi.wvalid && !w_got) begin
          if (w_cnt >= w_delay) begin
            axi.wready = 1'b1;
            w_got = 1'b1;
            w_cnt = 0;
            wr_data = axi.wdata;
            wr_strb = axi.wstrb;
          end else begin
            axi.wready = 1'b0;
            w_cnt++;
          end
        end else axi.wready = 1'b0;
        if (axi.arvalid && !ar_got) begin
          if (ar_cnt >= ar_delay) begin
            axi.arready = 1'b1;
            ar_got = 1'b1;
            ar_cnt = 0;
            rd_addr = axi.araddr;
          end else begin
            axi.arready = 1'b0;
            ar_cnt++;
          end
        end else axi.arready = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n = 0;
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check_eq("cmd_accept", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic check_rsp(input string tag, input logic we, input logic [31:0] rdata,
                           input logic [1:0] resp, input logic [15:0] cycles);
    check_eq({tag, "_we"}, rsp_we, we);
    check_eq({tag, "_rdata"}, rsp_rdata, rdata);
    check_eq({tag, "_resp"}, rsp_resp, resp);
    check_eq({tag, "_cycles"}, rsp_cycles, cycles);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int budget,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                          input logic [15:0] exp_cycles);
    send_cmd(we, addr, data, strb);
    wait_rsp(tag, budget);
    check_rsp(tag, we, exp_rdata, exp_resp, exp_cycles);
    release_rsp();
  endtask

  initial begin
    int base_aw, base_b, base_wd;

    // Reset state
    repeat (3) @(negedge aclk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                            rsp_valid}, 0);
    check_eq("rst_data", {rsp_rdata, rsp_cycles, rsp_resp, axi.awaddr}, 0);
    areset = 1'b0;
    #1;
    check_eq("rel_cmd_ready", cmd_ready, 1);

    // Zero-wait write: single AW handshake, bready for exactly one cycle
    base_aw = aw_hs_cnt;
    base_b  = bready_cyc;
    transact("t1_wr", 1'b1, 32'h0, 32'h2, 4'hF, 20, 32'h0, 2'b00, 16'd2);
    check_eq("t1_aw_hs", aw_hs_cnt - base_aw, 1);
    check_eq("t1_bready_cyc", bready_cyc - base_b, 1);

    // AW ready delayed 3 cycles, W immediate: wvalid low while awvalid holds
    aw_delay = 3;
    base_wd  = w_drop_cnt;
    transact("t2_wr", 1'b1, 32'h4, 32'h3, 4'hF, 30, 32'h0, 2'b00, 16'd5);
    check_eq("t2_w_drop", w_drop_cnt - base_wd, 3);
    aw_delay = 0;

    // Reads with AR delayed: araddr stable, data from the bank
    ar_delay = 2;
    transact("t3_rd8", 1'b0, 32'h8, 32'h0, 4'h0, 30, 32'h0, 2'b00, 16'd4);
    check_eq("t3_araddr", rd_addr, 32'h8);
    check_eq("t3_ar_stable", ar_unstable, 0);
    ar_delay = 0;
    transact("t3_wr_strb", 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 20, 32'h0, 2'b00, 16'd2);
    transact("t3_rd8b", 1'b0, 32'h8, 32'h0, 4'h0, 20, 32'h00BB00DD, 2'b00, 16'd2);
    transact("t3_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 20, 32'h3, 2'b00, 16'd2);

    // Saturating latency counter, then a fresh command starts from zero
    r_delay = 70000;
    transact("t4_sat", 1'b0, 32'h0, 32'h0, 4'h0, 80000, 32'h2, 2'b00, 16'hFFFF);
    r_delay = 0;
    transact("t4_after", 1'b0, 32'h0, 32'h0, 4'h0, 20, 32'h2, 2'b00, 16'd2);

    // SLVERR passthrough and response held while rsp_ready is low
    bresp_cfg = 2'b10;
    send_cmd(1'b1, 32'hC, 32'h5, 4'hF);
    wait_rsp("t5_err", 20);
    for (int i = 0; i < 10; i++) begin
      check_eq("t5_hold", {rsp_valid, cmd_ready, rsp_we, rsp_resp, rsp_rdata, rsp_cycles},
               {1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 16'd2});
      @(negedge aclk);
    end
    release_rsp();
    bresp_cfg = 2'b00;

    // Reset while waiting in the read-data phase
    r_delay = 20;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    for (int i = 0; i < 10 && !axi.rready; i++) @(negedge aclk);
    check_eq("t6_in_rd_data", axi.rready, 1);
    #1 areset = 1'b1;
    #1;
    check_eq("t6_async_clear", {axi.arvalid, axi.rready, rsp_valid, cmd_ready}, 0);
    repeat (2) @(negedge aclk);
    areset  = 1'b0;
    r_delay = 0;
    @(negedge aclk);
    check_eq("t6_no_stale", rsp_valid, 0);
    check_eq("t6_ready", cmd_ready, 1);
    transact("t6_rd", 1'b0, 32'h4, 32'h0, 4'h0, 20, 32'h3, 2'b00, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
